// File: rtl/i2c_tgt_pkg.sv
// Shared types and constants for the I2C target register file.
package i2c_tgt_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_DATA_W = 8;
  localparam logic [I2C_ADDR_W-1:0] GENCALL_ADDR = 7'h00;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } state_t;

endpackage

// File: rtl/i2c_tgt_sync.sv
// Two-flop synchronizers for SCL/SDA plus edge, START and STOP detection.
module i2c_tgt_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_sync
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_d;
  logic       sda_d;
  logic [1:0] fill;
  logic       live;

  // Synchronizer chains, one-cycle history, and a fill counter that masks
  // edges until every stage holds a real sample (the flops preset to 1, so
  // a bus parked with SDA low would otherwise look like a START after reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_ff <= '1;
      sda_ff <= '1;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
      fill   <= '0;
    end else begin
      scl_ff <= {scl_ff[0], scl};
      sda_ff <= {sda_ff[0], sda_in};
      scl_d  <= scl_ff[1];
      sda_d  <= sda_ff[1];
      if (fill != 2'd3) fill <= fill + 2'd1;
    end
  end

  // Edge and bus-condition decode on the synchronized values.
  always_comb begin
    live      = (fill == 2'd3);
    sda_sync  = sda_ff[1];
    scl_rise  = live &  scl_ff[1] & ~scl_d;
    scl_fall  = live & ~scl_ff[1] &  scl_d;
    start_det = live & scl_ff[1] & scl_d &  sda_d & ~sda_ff[1];
    stop_det  = live & scl_ff[1] & scl_d & ~sda_d &  sda_ff[1];
  end

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with an 8-bit register file: first write byte sets the
// pointer, further write bytes store at the pointer, reads stream from it.
// Optional: define I2C_TGT_GENCALL_EN to also accept general-call writes.
module i2c_target_regfile
  import i2c_tgt_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TGT_ADDR  = 7'h50,
  parameter int unsigned           MEM_DEPTH = 16,
  localparam int unsigned          PW        = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic                  busy,
  output logic                  wr_strobe,
  output logic [PW-1:0]         wr_addr,
  output logic [I2C_DATA_W-1:0] wr_data,
  output logic [2:0]            bit_cnt
);

  state_t                state;
  logic [I2C_DATA_W-1:0] shreg;
  logic [I2C_DATA_W-1:0] rx_byte;
  logic [PW-1:0]         ptr;
  logic                  ack_on;
  logic                  rw;
  logic                  addr_hit;
  logic [I2C_DATA_W-1:0] mem [MEM_DEPTH];

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_tgt_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_sync  (sda_s)
  );

  // Byte completed by the current SCL rise and its address decode.
  always_comb begin
    rx_byte  = {shreg[I2C_DATA_W-2:0], sda_s};
    addr_hit = (rx_byte[7:1] == TGT_ADDR);
`ifdef I2C_TGT_GENCALL_EN
    if (rx_byte[7:1] == GENCALL_ADDR && !rx_byte[0]) addr_hit = 1'b1;
`endif
  end

  // Protocol FSM, register file and registered outputs. ACK states use
  // ack_on to tell the fall that starts the ninth bit from the fall ending it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      bit_cnt   <= 3'd7;
      ptr       <= '0;
      shreg     <= '0;
      ack_on    <= 1'b0;
      rw        <= 1'b0;
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= 3'd7;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        ack_on  <= 1'b0;
      end else if (stop_det) begin
        state   <= IDLE;
        bit_cnt <= 3'd7;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        ack_on  <= 1'b0;
      end else begin
        case (state)
          ADDR, PTR, WDATA: begin
            if (scl_rise) begin
              shreg <= rx_byte;
              if (bit_cnt == 3'd0) begin
                bit_cnt <= 3'd7;
                ack_on  <= 1'b0;
                if (state == ADDR) begin
                  if (addr_hit) begin
                    state <= ADDR_ACK;
                    busy  <= 1'b1;
                    rw    <= rx_byte[0];
                  end else begin
                    state <= IGNORE;
                  end
                end else if (state == PTR) begin
                  ptr   <= rx_byte[PW-1:0];
                  state <= PTR_ACK;
                end else begin
                  mem[ptr]  <= rx_byte;
                  wr_strobe <= 1'b1;
                  wr_addr   <= ptr;
                  wr_data   <= rx_byte;
                  ptr       <= ptr + PW'(1);
                  state     <= WDATA_ACK;
                end
              end else begin
                bit_cnt <= bit_cnt - 3'd1;
              end
            end
          end
          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= 1'b1;
                ack_on <= 1'b1;
              end else begin
                ack_on <= 1'b0;
                if (state == ADDR_ACK && rw) begin
                  state  <= RDATA;
                  shreg  <= mem[ptr];
                  sda_oe <= ~mem[ptr][7];
                end else begin
                  state  <= (state == ADDR_ACK) ? PTR : WDATA;
                  sda_oe <= 1'b0;
                end
              end
            end
          end
          RDATA: begin
            if (scl_rise) begin
              if (bit_cnt == 3'd0) begin
                bit_cnt <= 3'd7;
                ack_on  <= 1'b0;
                state   <= RDATA_ACK;
              end else begin
                bit_cnt <= bit_cnt - 3'd1;
              end
            end
            if (scl_fall) begin
              shreg  <= {shreg[I2C_DATA_W-2:0], 1'b0};
              sda_oe <= ~shreg[I2C_DATA_W-2];
            end
          end
          RDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= 1'b0;
                ack_on <= 1'b1;
                ptr    <= ptr + PW'(1);
              end else begin
                ack_on <= 1'b0;
                state  <= RDATA;
                shreg  <= mem[ptr];
                sda_oe <= ~mem[ptr][7];
              end
            end else if (scl_rise && ack_on && sda_s) begin
              state <= IGNORE;
            end
          end
          IDLE, IGNORE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_target_regfile.md
I2C_TARGET_REGFILE -- requirements
Module: i2c_target_regfile

Interface
REQ-001 SHALL have parameter: TGT_ADDR, 7'h50, 7-bit target address matched against the received address byte.
REQ-002 SHALL have parameter: MEM_DEPTH, 16, number of 8-bit registers (power of two, 2..256); PW = $clog2(MEM_DEPTH).
REQ-003 SHALL have port: clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: scl  input  1  I2C clock from the bus master (asynchronous to clk).
REQ-006 SHALL have port: sda_in  input  1  sampled SDA line level (asynchronous to clk).
REQ-007 SHALL have port: sda_oe  output  1  1 = drive SDA low (open-drain), 0 = release.
REQ-008 SHALL have port: busy  output  1  high from address match until the next STOP/START.
REQ-009 SHALL have port: wr_strobe  output  1  one-clk pulse per register write.
REQ-010 SHALL have port: wr_addr  output  PW  register index written on wr_strobe.
REQ-011 SHALL have port: wr_data  output  8  byte written on wr_strobe.
REQ-012 SHALL have port: bit_cnt  output  3  debug: bit index within the current byte.

Function
REQ-013 SHALL pass scl and sda_in through 2-flop synchronizers and detect edges on the synchronized values; scl high and low phases are each at least 4 clk.
REQ-014 SHALL detect START as synced SDA falling while synced SCL is high, and STOP as synced SDA rising while synced SCL is high.
REQ-015 SHALL sample SDA on synced SCL rising edges and change sda_oe exactly 1 clk after a detected synced SCL falling edge.
REQ-016 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-017 SHALL, on START in any state, enter ADDR with bit_cnt=7, release sda_oe, and keep the register pointer (repeated START).
REQ-018 SHALL, on STOP in any state, enter IDLE, release sda_oe and deassert busy.
REQ-019 SHALL, after 8 address bits with a matching address, drive ACK (sda_oe=1) for the ninth SCL period; R/W=0 -> PTR, R/W=1 -> RDATA.
REQ-020 SHALL, on an address mismatch, leave sda_oe=0 (NACK) and enter IGNORE until START/STOP.
REQ-021 SHALL load the first write byte into the pointer (low PW bits only; upper bits ignored), ACK it, then go to WDATA.
REQ-022 SHALL, per WDATA byte, store it at mem[pointer], pulse wr_strobe with wr_addr=pointer and wr_data=byte on the 8th SCL rising edge, ACK it, and increment the pointer.
REQ-023 SHALL, in RDATA, load mem[pointer] into the shift register on the SCL falling edge ending the ACK period, and shift it MSB first with sda_oe = ~bit.
REQ-024 SHALL, in RDATA_ACK, release SDA, increment the pointer, and sample the master's bit: 0 (ACK) -> RDATA with the next byte, 1 (NACK) -> IGNORE.
REQ-025 SHALL wrap the pointer from MEM_DEPTH-1 to 0 on increment.
REQ-026 SHALL keep bit_cnt counting 7 down to 0 during each byte.

Reset
REQ-027 SHALL, while rst=1, set state=IDLE, sda_oe=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0, bit_cnt=7, pointer=0, all mem entries=8'h00, synchronizer flops=1.
REQ-028 SHALL, on reset mid-transfer, abandon the transfer immediately, and after release ignore the bus until the next START.

Configuration
REQ-029 SHALL, with I2C_TGT_GENCALL_EN defined, also ACK address 7'h00 with R/W=0 and treat that transfer exactly as a matched write; 7'h00 with R/W=1 -> NACK and IGNORE.
REQ-030 SHALL, without I2C_TGT_GENCALL_EN, treat address 7'h00 as a mismatch (REQ-020).

Structure
REQ-031 SHALL take the state enum, I2C_ADDR_W=7, I2C_DATA_W=8 and GENCALL_ADDR=7'h00 from shared package i2c_tgt_pkg.
REQ-032 SHALL instantiate one sub-module, i2c_tgt_sync, which synchronizes scl/sda_in and outputs scl_rise, scl_fall, start_det and stop_det.

Verification
REQ-033 SHALL cover: START, 0xA0, 0x03, 0x5A, 0xC3, STOP -> three ACKs; wr_strobe at wr_addr 3 (5A), then 4 (C3); busy low after STOP.
REQ-034 SHALL cover: START, 0xA0, 0x03, repeated START, 0xA1, read 2 bytes with ACK then NACK -> SDA returns 5A, C3; sda_oe=0 after NACK.
REQ-035 SHALL cover: START, 0xA0, 0x0F, 0x11, 0x22, STOP -> mem[15]=11, mem[0]=22 (wrap).
REQ-036 SHALL cover: START, 0xB0 -> no ACK (sda_oe stays 0), no wr_strobe for subsequent bytes, busy=0.
REQ-037 SHALL cover: rst pulsed during the 4th data bit of a write -> sda_oe=0 immediately; mem reads back 00; next transfer completes normally.
REQ-038 SHALL cover: START, 0x00, 0x02, 0x77, STOP with and without I2C_TGT_GENCALL_EN -> mem[2]=77 with ACK, or NACK and no write.
